// File: rtl/max7219_pkg.sv
// rtl/max7219_pkg.sv - MAX7219 register map, init word list and frame FSM states
// Contents: register address constants, init_word() lookup, state_t enum.
// Build option: MAX7219_INIT_EN adds the ST_INIT state.
package max7219_pkg;

  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DIGIT1    = 8'h02;
  localparam logic [7:0] REG_DIGIT2    = 8'h03;
  localparam logic [7:0] REG_DIGIT3    = 8'h04;
  localparam logic [7:0] REG_DIGIT4    = 8'h05;
  localparam logic [7:0] REG_DIGIT5    = 8'h06;
  localparam logic [7:0] REG_DIGIT6    = 8'h07;
  localparam logic [7:0] REG_DIGIT7    = 8'h08;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int INIT_WORDS = 5;

  // Power-up sequence: test off, raw segment mode, all 8 rows, brightness,
  // then leave shutdown last so the panel never lights with stale settings.
  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
    logic [15:0] w;
    case (idx)
      3'd0:    w = {REG_TEST, 8'h00};
      3'd1:    w = {REG_DECODE, 8'h00};
      3'd2:    w = {REG_SCANLIMIT, 8'h07};
      3'd3:    w = {REG_INTENSITY, 4'h0, intensity};
      3'd4:    w = {REG_SHUTDOWN, 8'h01};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3
`ifdef MAX7219_INIT_EN
    ,
    ST_INIT  = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/spi_word_tx.sv
// rtl/spi_word_tx.sv - 16-bit MSB-first SPI word shifter with chip-select framing
// Ports: clk, rst (async high); start/word begin a transfer when idle;
//        done is high in the last cycle of bit 0's high half;
//        spi_cs (active low), spi_clk (idles low), spi_din.
module spi_word_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_din
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shreg;
  logic          half_end;

  assign half_end = active && (div_cnt == DIV_LAST);
  assign done     = half_end && spi_clk && (bit_cnt == 4'd15);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= 4'd0;
      shreg   <= 16'h0000;
      spi_cs  <= 1'b1;
      spi_clk <= 1'b0;
      spi_din <= 1'b0;
    end else if (start && !active) begin
      // CS drops together with bit 15 appearing on DIN.
      active  <= 1'b1;
      shreg   <= word;
      div_cnt <= '0;
      bit_cnt <= 4'd0;
      spi_cs  <= 1'b0;
      spi_clk <= 1'b0;
      spi_din <= word[15];
    end else if (active) begin
      if (half_end) begin
        div_cnt <= '0;
        if (!spi_clk) begin
          spi_clk <= 1'b1;
        end else begin
          spi_clk <= 1'b0;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            // CS rises with SCLK falling: the device latches the full word.
            active  <= 1'b0;
            spi_cs  <= 1'b1;
            spi_din <= 1'b0;
          end else begin
            shreg   <= {shreg[14:0], 1'b0};
            spi_din <= shreg[14];
          end
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/max7219_frame_tx.sv
// rtl/max7219_frame_tx.sv - change-triggered 8-word frame transmitter for a MAX7219 matrix
// Build option: MAX7219_INIT_EN sends the five-word device init after reset.
// Ports: clk, reset (async high); led_on[127:0] frame, word k = led_on[127-16k -: 16];
//        spi_cs, spi_clk, spi_din to the device; busy (not idle); frame_done pulse.
module max7219_frame_tx
  import max7219_pkg::*;
#(
  parameter int         CLK_DIV   = 4,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] led_on,
  output logic         spi_cs,
  output logic         spi_clk,
  output logic         spi_din,
  output logic         busy,
  output logic         frame_done
);

  localparam int GW = $clog2(2 * CLK_DIV);
  localparam logic [GW-1:0] GAP_LAST = GW'(2 * CLK_DIV - 1);

`ifdef MAX7219_INIT_EN
  localparam state_t RESET_STATE = ST_INIT;
`else
  localparam state_t RESET_STATE = ST_IDLE;
`endif

  state_t         state, state_n;
  logic [127:0]   frame_buf;
  logic [127:0]   last_sent;
  logic           first_frame;
  logic [2:0]     word_idx;
  logic [GW-1:0]  gap_cnt;
  logic           gap_end;
  logic           change;
  logic           start;
  logic           done;
  logic           frame_done_n;
  logic [6:0]     bit_base;
  logic [15:0]    frame_word;
  logic [15:0]    tx_word;

`ifdef MAX7219_INIT_EN
  logic           init_phase;
  logic [2:0]     init_idx;
`endif

  assign change     = first_frame || (led_on != last_sent);
  assign gap_end    = (gap_cnt == GAP_LAST);
  assign bit_base   = {3'd7 - word_idx, 4'b0000};
  assign frame_word = frame_buf[bit_base +: 16];

`ifdef MAX7219_INIT_EN
  assign tx_word = init_phase ? init_word(init_idx, INTENSITY) : frame_word;
`else
  assign tx_word = frame_word;
`endif

  always_comb begin
    state_n      = state;
    start        = 1'b0;
    frame_done_n = 1'b0;
    case (state)
`ifdef MAX7219_INIT_EN
      ST_INIT:  state_n = ST_LOAD;
`endif
      ST_IDLE:  if (change) state_n = ST_LOAD;
      ST_LOAD: begin
        start   = 1'b1;
        state_n = ST_SHIFT;
      end
      ST_SHIFT: if (done) state_n = ST_GAP;
      ST_GAP: begin
        if (gap_end) begin
`ifdef MAX7219_INIT_EN
          if (init_phase) begin
            state_n = (init_idx == 3'(INIT_WORDS - 1)) ? ST_IDLE : ST_INIT;
          end else
`endif
          if (word_idx == 3'd7) begin
            state_n      = ST_IDLE;
            frame_done_n = 1'b1;
          end else begin
            state_n = ST_LOAD;
          end
        end
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RESET_STATE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_buf   <= '0;
      last_sent   <= '0;
      first_frame <= 1'b1;
      word_idx    <= 3'd0;
      gap_cnt     <= '0;
`ifdef MAX7219_INIT_EN
      init_phase  <= 1'b1;
      init_idx    <= 3'd0;
`endif
    end else begin
      state      <= state_n;
      busy       <= (state_n != ST_IDLE);
      frame_done <= frame_done_n;

      // The snapshot decouples the frame in flight from later led_on changes.
      if (state == ST_IDLE && change) begin
        frame_buf   <= led_on;
        last_sent   <= led_on;
        first_frame <= 1'b0;
        word_idx    <= 3'd0;
      end

      if (state == ST_GAP) begin
        if (gap_end) begin
          gap_cnt <= '0;
`ifdef MAX7219_INIT_EN
          if (init_phase) begin
            if (init_idx == 3'(INIT_WORDS - 1)) init_phase <= 1'b0;
            else                                init_idx   <= init_idx + 3'd1;
          end else
`endif
          if (word_idx != 3'd7) word_idx <= word_idx + 3'd1;
        end else begin
          gap_cnt <= gap_cnt + GW'(1);
        end
      end
    end
  end

  spi_word_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_spi_word_tx (
    .clk     (clk),
    .rst     (reset),
    .start   (start),
    .word    (tx_word),
    .done    (done),
    .spi_cs  (spi_cs),
    .spi_clk (spi_clk),
    .spi_din (spi_din)
  );

endmodule

// File: tb/tb_max7219_frame_tx.sv
// tb/tb_max7219_frame_tx.sv - self-checking bench for max7219_frame_tx
module tb_max7219_frame_tx;

`ifdef MAX7219_INIT_EN
  localparam int NINIT = 5;
`else
  localparam int NINIT = 0;
`endif

  localparam logic [127:0] FRAME0 = 128'h0100_0200_0300_0400_0500_0600_0700_0800;
  localparam logic [127:0] FRAME1 = 128'h0100_0200_0320_0400_0500_0600_0700_0800;
  localparam logic [127:0] FRAME2 = 128'h0181_0242_0324_0418_0518_0624_0742_0881;
  localparam logic [127:0] FRAME3 = 128'h01FF_0200_03FF_0400_05FF_0600_07FF_0800;
  localparam logic [127:0] FRAME4 = 128'h0111_0222_0333_0444_0555_0666_0777_0888;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] led_on;
  logic         spi_cs, spi_clk, spi_din, busy, frame_done;

  logic         rst4;
  logic [127:0] led4;
  logic         cs4, sclk4, din4, busy4, fd4;

  max7219_frame_tx #(.CLK_DIV(1), .INTENSITY(4'h8)) u_dut (
    .clk(clk), .reset(rst), .led_on(led_on), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_din(spi_din), .busy(busy), .frame_done(frame_done)
  );

  max7219_frame_tx #(.CLK_DIV(4), .INTENSITY(4'h8)) u_dut4 (
    .clk(clk), .reset(rst4), .led_on(led4), .spi_cs(cs4), .spi_clk(sclk4),
    .spi_din(din4), .busy(busy4), .frame_done(fd4)
  );

  int checks = 0;
  int passed = 0;

  logic [15:0] init_exp [5] = '{16'h0F00, 16'h0900, 16'h0B07, 16'h0A08, 16'h0C01};

  // Pin-level decoder: only complete 16-bit words framed by CS are recorded.
  logic [15:0] words[$];
  logic [15:0] sh = 16'h0000;
  int          nbits = 0;
  int          cs_falls = 0;
  logic        cs_q = 1'b1;
  int          fd_cnt = 0;

  always @(posedge spi_clk or posedge spi_cs or negedge spi_cs) begin
    if (spi_cs !== cs_q) begin
      if (spi_cs === 1'b0) begin
        nbits = 0;
        cs_falls++;
      end else if (nbits == 16) begin
        words.push_back(sh);
      end
      cs_q = spi_cs;
    end else if (spi_clk === 1'b1 && spi_cs === 1'b0) begin
      sh = {sh[14:0], spi_din};
      nbits++;
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  function automatic logic [15:0] wk(input logic [127:0] f, input int k);
    return f[127 - 16*k -: 16];
  endfunction

  task automatic wait_words(input int n, input int budget, output bit ok);
    int c = 0;
    while (words.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    ok = (words.size() >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1; led_on = FRAME0; led4 = FRAME1;
    repeat (3) @(negedge clk);
    checks++; if (spi_cs !== 1'b1) $display("FAIL reset_cs got %b want 1", spi_cs); else passed++;
    checks++; if (spi_clk !== 1'b0) $display("FAIL reset_clk got %b want 0", spi_clk); else passed++;
    checks++; if (spi_din !== 1'b0) $display("FAIL reset_din got %b want 0", spi_din); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
    checks++; if (cs4 !== 1'b1) $display("FAIL reset_cs4 got %b want 1", cs4); else passed++;
  endtask

  task automatic test_first_frame;
    bit ok;
    int c;
    words.delete();
    @(negedge clk) rst = 1'b0;
    wait_words(NINIT + 8, 3000, ok);
    checks++; if (!ok) $display("FAIL first_frame_words got %0d want %0d", words.size(), NINIT + 8); else passed++;
    for (int i = 0; i < NINIT; i++) begin
      checks++;
      if (words[i] !== init_exp[i]) $display("FAIL init_word%0d got %h want %h", i, words[i], init_exp[i]);
      else passed++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (words[NINIT + k] !== wk(FRAME0, k)) $display("FAIL frame0_word%0d got %h want %h", k, words[NINIT + k], wk(FRAME0, k));
      else passed++;
    end
    c = 0;
    while (fd_cnt < 1 && c < 100) begin @(negedge clk); c++; end
    checks++; if (fd_cnt !== 1) $display("FAIL first_frame_done_count got %0d want 1", fd_cnt); else passed++;
  endtask

  task automatic test_change;
    int n;
    int fd0;
    words.delete();
    fd0 = fd_cnt;
    @(negedge clk) led_on = FRAME1;
    n = 0;
    while (n < 400) begin
      @(posedge clk); #1;
      n++;
      if (frame_done === 1'b1) break;
    end
    checks++; if (n != 8*35 + 1) $display("FAIL change_latency got %0d want %0d", n, 8*35 + 1); else passed++;
    repeat (20) @(negedge clk);
    checks++; if (words.size() != 8) $display("FAIL change_word_count got %0d want 8", words.size()); else passed++;
    checks++; if (words[2] !== 16'h0320) $display("FAIL change_word2 got %h want 0320", words[2]); else passed++;
    checks++; if (fd_cnt - fd0 != 1) $display("FAIL change_done_pulses got %0d want 1", fd_cnt - fd0); else passed++;
  endtask

  task automatic test_hold;
    int c0;
    int busy_hits;
    c0 = cs_falls;
    busy_hits = 0;
    repeat (1000) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_hits++;
    end
    checks++; if (cs_falls != c0) $display("FAIL hold_cs_activity got %0d want 0", cs_falls - c0); else passed++;
    checks++; if (busy_hits != 0) $display("FAIL hold_busy got %0d busy cycles want 0", busy_hits); else passed++;
  endtask

  task automatic test_mid_change;
    bit ok;
    int c;
    int fd0;
    words.delete();
    fd0 = fd_cnt;
    @(negedge clk) led_on = FRAME2;
    wait_words(3, 500, ok);
    c = 0;
    while (nbits < 4 && c < 100) begin @(negedge clk); c++; end
    led_on = FRAME3;
    wait_words(16, 2000, ok);
    checks++; if (!ok) $display("FAIL mid_change_words got %0d want 16", words.size()); else passed++;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (words[k] !== wk(FRAME2, k)) $display("FAIL mid_old_word%0d got %h want %h", k, words[k], wk(FRAME2, k));
      else passed++;
      checks++;
      if (words[8 + k] !== wk(FRAME3, k)) $display("FAIL mid_new_word%0d got %h want %h", k, words[8 + k], wk(FRAME3, k));
      else passed++;
    end
    c = 0;
    while (fd_cnt - fd0 < 2 && c < 100) begin @(negedge clk); c++; end
    checks++; if (fd_cnt - fd0 != 2) $display("FAIL mid_done_pulses got %0d want 2", fd_cnt - fd0); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int c;
    words.delete();
    @(negedge clk) led_on = FRAME4;
    wait_words(4, 500, ok);
    c = 0;
    while (nbits < 8 && c < 100) begin @(negedge clk); c++; end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (spi_cs !== 1'b1) $display("FAIL midreset_cs got %b want 1", spi_cs); else passed++;
    checks++; if (spi_clk !== 1'b0) $display("FAIL midreset_clk got %b want 0", spi_clk); else passed++;
    @(negedge clk);
    words.delete();
    @(negedge clk) rst = 1'b0;
    wait_words(NINIT + 8, 3000, ok);
    checks++; if (!ok) $display("FAIL restart_words got %0d want %0d", words.size(), NINIT + 8); else passed++;
    for (int i = 0; i < NINIT; i++) begin
      checks++;
      if (words[i] !== init_exp[i]) $display("FAIL restart_init%0d got %h want %h", i, words[i], init_exp[i]);
      else passed++;
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (words[NINIT + k] !== wk(FRAME4, k)) $display("FAIL restart_word%0d got %h want %h", k, words[NINIT + k], wk(FRAME4, k));
      else passed++;
    end
  endtask

  task automatic test_clkdiv4;
    int n;
    @(negedge clk) rst4 = 1'b0;
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1; n++;
      if (cs4 === 1'b0) break;
    end
    checks++; if (n != 2) $display("FAIL div4_cs_fall got %0d cycles want 2", n); else passed++;
    for (int h = 0; h < 3; h++) begin
      logic lvl;
      lvl = (h % 2 == 0) ? 1'b1 : 1'b0;
      n = 0;
      while (n < 20) begin
        @(posedge clk); #1; n++;
        if (sclk4 === lvl) break;
      end
      checks++; if (n != 4) $display("FAIL div4_half%0d got %0d cycles want 4", h, n); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_change();
    test_hold();
    test_mid_change();
    test_reset_mid();
    test_clkdiv4();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/max7219_frame_tx.md
# max7219_frame_tx

Serialises the 128-bit LED-matrix frame from the level-pattern stage into MAX7219 SPI writes. The frame is eight `{row address, row data}` byte pairs. The block sits directly downstream of the pattern selector and drives the 8x8 matrix pins. After reset it can optionally issue the MAX7219 initialisation sequence. It then transmits a full frame whenever the incoming pattern differs from the last frame sent.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SPI half-period. Legal range is 1 to 255.
- `INTENSITY`, default 4'h8: value written to the intensity register (0x0A).
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: **one clock; reset is asynchronous and active-high**.
- `led_on` input, 128 bits: frame. Word k (k=0..7) is `led_on[127-16k -: 16]`, i.e. `{addr, data}`. Word 0 is sent first.
- `spi_cs` output, 1 bit: chip select, active-low. The MAX7219 latches a word on its rising edge.
- `spi_clk` output, 1 bit: serial clock. Idles low.
- `spi_din` output, 1 bit: serial data, MSB first.
- `busy` output, 1 bit: high while an init or frame transfer is in progress.
- `frame_done` output, 1 bit: one-cycle pulse after the last word of a frame completes.

## Operation
- Reset values:
  - `spi_cs`=1, `spi_clk`=0, `spi_din`=0, `busy`=0, `frame_done`=0.
  - Last-sent register is cleared to 0.
  - `first_frame` flag is set to 1.
- States: INIT → IDLE → LOAD → SHIFT → GAP, then back to LOAD or IDLE.
- INIT (only when the init feature is compiled in) sends five words, in this order:
  - 0x0F00 (display test off)
  - 0x0900 (no decode)
  - 0x0B07 (scan all 8 rows)
  - `{8'h0A, 4'h0, INTENSITY}`
  - 0x0C01 (leave shutdown)
  - Then goes to IDLE.
- IDLE:
  - If `first_frame` is set, or `led_on` != last-sent, snapshot `led_on` into the frame buffer and the last-sent register, clear `first_frame`, set the word index to 0, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: load word[index] into the 16-bit shifter and go to SHIFT.
- SHIFT: shift 16 bits, then go to GAP.
- GAP:
  - Hold `spi_cs` high for 2·CLK_DIV cycles.
  - Then, if the index is below 7, increment it and go to LOAD.
  - Otherwise pulse `frame_done` and go to IDLE.
  - During INIT, the GAP exit returns to INIT until all five init words are sent.
- Changes to `led_on` during a transfer are ignored. The frame in flight always completes from the snapshot. A new differing value is picked up in the next IDLE cycle.
- `busy` is 1 in every state except IDLE.

## Timing
- Each bit takes 2·CLK_DIV cycles: `spi_clk` low for CLK_DIV cycles with `spi_din` valid, then high for CLK_DIV cycles. `spi_din` is stable across the rising edge.
- `spi_cs` falls in the same cycle that bit 15 is driven. It rises on the cycle after bit 0's high half ends, together with `spi_clk` returning low.
- Word period: 32·CLK_DIV shift cycles, plus 2·CLK_DIV gap cycles, plus 1 LOAD cycle.
- Frame latency: IDLE detect to `frame_done` = 8·(34·CLK_DIV+1)+1 cycles.
- The divider counter is $clog2(CLK_DIV+1) bits wide. The bit counter is 4 bits and wraps 15→0 exactly once per word.
- Asserting `reset` mid-transfer immediately forces `spi_cs`=1 and `spi_clk`=0. After deassertion the block restarts from INIT (or IDLE), and a partial word is never latched.
- A `led_on` change and `frame_done` in the same cycle: the change is detected in the following IDLE cycle.

## Configuration
- `MAX7219_INIT_EN` defined: after reset, the block sends the five-word INIT sequence before the first frame.
- Not defined: the INIT state is absent. Reset goes straight to IDLE, and the first frame begins on the first cycle after reset deasserts (`first_frame`=1). The external controller owns device setup.

## Structure
- Package `max7219_pkg` holds:
  - register address constants (DIGIT0..7 = 0x01..0x08, DECODE 0x09, INTENSITY 0x0A, SCANLIMIT 0x0B, SHUTDOWN 0x0C, TEST 0x0F);
  - the init word list;
  - the state `typedef enum`.
- Sub-module `spi_word_tx` contains the divider, the 16-bit shifter, the bit counter and the CS/CLK/DIN generation. It exposes a `start`/`done` handshake per word. The top level holds the state machine, the frame buffer and change detection.

## Test plan
- Reset with INIT enabled, CLK_DIV=1 → five words are decoded from the pins in order: 0x0F00, 0x0900, 0x0B07, 0x0A08, 0x0C01. Then frame words 0x0100…0x0800 follow, with `led_on`=0x0100_0200_0300_0400_0500_0600_0700_0800.
- Change `led_on` to the level-1 pattern (word 2 = 0x0320) in IDLE → exactly 8 words are sent, including 0x0320. `frame_done` pulses once, 8·35+1 cycles after detection.
- Hold `led_on` constant after a frame → no `spi_cs` activity for 1000 cycles, and `busy`=0.
- Change `led_on` mid-word 3 → the current frame carries the old data. A second frame with the new data follows immediately.
- Assert `reset` during bit 7 of word 4 → `spi_cs`=1 and `spi_clk`=0 within the same cycle, and the sequence restarts cleanly from INIT.
- CLK_DIV=4, build without MAX7219_INIT_EN → the first `spi_cs` fall occurs within 2 cycles of reset release, and each `spi_clk` half-period is 4 cycles.
